// File: rtl/dr_alu_hs.sv
// Dual-rail (NULL/DATA) ALU behind a clocked four-phase handshake.
// Captures a complete DATA wavefront, holds the dual-rail result until the consumer requests NULL.
module dr_alu_hs #(
  parameter int WIDTH   = 5,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2*WIDTH-1:0] a_dr,
  input  logic [2*WIDTH-1:0] b_dr,
  input  logic [1:0]         sel0_dr,
  input  logic [1:0]         sel1_dr,
  input  logic [1:0]         cin_dr,
  input  logic               ki,
  input  logic               clr_err,
  output logic               ko,
  output logic [2*WIDTH-1:0] out_dr,
  output logic [1:0]         ovf_dr,
  output logic [1:0]         neg_dr,
  output logic [1:0]         zero_dr,
  output logic               err_enc,
  output logic               err_timeout,
  output logic [CNT_W-1:0]   txn_count
);

  localparam int NPAIRS = 2*WIDTH + 3;
  localparam int TO_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

  typedef enum logic {WAIT_DATA = 1'b0, HOLD_DATA = 1'b1} state_t;

  function automatic logic [1:0] enc_bit(input logic v);
    return v ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [2*WIDTH-1:0] enc_word(input logic [WIDTH-1:0] v);
    logic [2*WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) r[2*i +: 2] = enc_bit(v[i]);
    return r;
  endfunction

  state_t            state, state_next;
  logic [TO_W-1:0]   to_cnt, to_next;
  logic [2*NPAIRS-1:0] rails;
  logic              complete, all_null, illegal, partial;
  logic [WIDTH-1:0]  a_val, b_val, res;
  logic [1:0]        op;
  logic              cin_val, ovf;
  logic              capture, release_out, enc_hit, to_hit;

  assign rails = {cin_dr, sel1_dr, sel0_dr, b_dr, a_dr};

  // Wavefront classification over every rail pair of every input bus.
  always_comb begin
    complete = 1'b1;
    all_null = 1'b1;
    illegal  = 1'b0;
    for (int p = 0; p < NPAIRS; p++) begin
      complete = complete & (rails[2*p] ^ rails[2*p+1]);
      all_null = all_null & ~(rails[2*p] | rails[2*p+1]);
      illegal  = illegal | (rails[2*p] & rails[2*p+1]);
    end
  end

  assign partial = ~(complete | all_null | illegal);

  // The true rail of each pair carries the logical value once the wavefront is complete.
  always_comb begin
    a_val = '0;
    b_val = '0;
    for (int i = 0; i < WIDTH; i++) begin
      a_val[i] = a_dr[2*i+1];
      b_val[i] = b_dr[2*i+1];
    end
  end

  assign op      = {sel1_dr[1], sel0_dr[1]};
  assign cin_val = cin_dr[1];

  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (op)
      2'b00: begin
        res = a_val + b_val + WIDTH'(cin_val);
        ovf = (a_val[WIDTH-1] == b_val[WIDTH-1]) && (res[WIDTH-1] != a_val[WIDTH-1]);
      end
      2'b01: begin
        res = a_val - b_val - WIDTH'(cin_val);
        ovf = (a_val[WIDTH-1] != b_val[WIDTH-1]) && (res[WIDTH-1] != a_val[WIDTH-1]);
      end
      2'b10:   res = a_val ^ b_val;
      default: res = a_val & b_val;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    capture     = 1'b0;
    release_out = 1'b0;
    enc_hit     = 1'b0;
    to_hit      = 1'b0;
    to_next     = '0;
    case (state)
      WAIT_DATA: begin
        enc_hit = illegal;
        if (complete && ki) begin
          capture    = 1'b1;
          state_next = HOLD_DATA;
        end
        if (partial) begin
          to_next = (to_cnt == TO_LIMIT) ? to_cnt : to_cnt + 1'b1;
          to_hit  = (TIMEOUT != 0) && (to_next == TO_LIMIT);
        end
      end
      HOLD_DATA: begin
        if (all_null && !ki) begin
          release_out = 1'b1;
          state_next  = WAIT_DATA;
        end
      end
      default: state_next = WAIT_DATA;
    endcase
  end

  assign ko = (state == WAIT_DATA);

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_DATA;
      to_cnt      <= '0;
      out_dr      <= '0;
      ovf_dr      <= 2'b00;
      neg_dr      <= 2'b00;
      zero_dr     <= 2'b00;
      err_enc     <= 1'b0;
      err_timeout <= 1'b0;
      txn_count   <= '0;
    end else begin
      state  <= state_next;
      to_cnt <= to_next;
      if (capture) begin
        out_dr    <= enc_word(res);
        ovf_dr    <= enc_bit(ovf);
        neg_dr    <= enc_bit(res[WIDTH-1]);
        zero_dr   <= enc_bit(res == '0);
        txn_count <= txn_count + 1'b1;
      end else if (release_out) begin
        out_dr  <= '0;
        ovf_dr  <= 2'b00;
        neg_dr  <= 2'b00;
        zero_dr <= 2'b00;
      end
      // Clearing wins over a same-cycle error event.
      if (clr_err)      err_enc <= 1'b0;
      else if (enc_hit) err_enc <= 1'b1;
      if (clr_err)     err_timeout <= 1'b0;
      else if (to_hit) err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dr_alu_hs.sv
// Self-checking bench for dr_alu_hs: directed handshake/error steps plus exhaustive and
// random ALU transactions checked against an integer-arithmetic reference model.
module tb_dr_alu_hs;

  localparam int W  = 5;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2*W-1:0] a_dr, b_dr;
  logic [1:0]    sel0_dr, sel1_dr, cin_dr;
  logic          ki, clr_err;
  logic          ko;
  logic [2*W-1:0] out_dr;
  logic [1:0]    ovf_dr, neg_dr, zero_dr;
  logic          err_enc, err_timeout;
  logic [15:0]   txn_count;

  int checks = 0;
  int passed = 0;
  int failed = 0;
  logic [15:0] exp_txn = '0;

  dr_alu_hs #(.WIDTH(W), .TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .a_dr(a_dr), .b_dr(b_dr), .sel0_dr(sel0_dr),
    .sel1_dr(sel1_dr), .cin_dr(cin_dr), .ki(ki), .clr_err(clr_err), .ko(ko),
    .out_dr(out_dr), .ovf_dr(ovf_dr), .neg_dr(neg_dr), .zero_dr(zero_dr),
    .err_enc(err_enc), .err_timeout(err_timeout), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end

  function automatic logic [1:0] e1(input logic v);
    return v ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [2*W-1:0] enc(input logic [W-1:0] v);
    logic [2*W-1:0] r;
    for (int i = 0; i < W; i++) r[2*i +: 2] = e1(v[i]);
    return r;
  endfunction

  function automatic logic [W-1:0] dec(input logic [2*W-1:0] d);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = d[2*i+1];
    return r;
  endfunction

  // Reference: exact integer arithmetic, overflow = true result outside the signed range.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                       input logic cin, output logic [W-1:0] res, output logic ovf);
    int sa, sb, r;
    sa = (int'(a) >= 16) ? int'(a) - 32 : int'(a);
    sb = (int'(b) >= 16) ? int'(b) - 32 : int'(b);
    case (op)
      2'd0:    r = sa + sb + int'(cin);
      2'd1:    r = sa - sb - int'(cin);
      2'd2:    r = int'(a ^ b);
      default: r = int'(a & b);
    endcase
    ovf = (op < 2'd2) && (r < -16 || r > 15);
    res = r[W-1:0];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_data(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [1:0] op, input logic cin);
    a_dr    = enc(a);
    b_dr    = enc(b);
    sel0_dr = e1(op[0]);
    sel1_dr = e1(op[1]);
    cin_dr  = e1(cin);
  endtask

  task automatic drive_null();
    a_dr = '0; b_dr = '0; sel0_dr = 2'b00; sel1_dr = 2'b00; cin_dr = 2'b00;
  endtask

  task automatic capture(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] op, input logic cin);
    logic [W-1:0] res;
    logic ovf;
    drive_data(a, b, op, cin);
    ki = 1'b1;
    step();
    model(a, b, op, cin, res, ovf);
    exp_txn = exp_txn + 1'b1;
    check("data", {15'd0, ko, out_dr, ovf_dr, neg_dr, zero_dr},
          {15'd0, 1'b0, enc(res), e1(ovf), e1(res[W-1]), e1(res == '0)});
    check("txn", {16'd0, txn_count}, {16'd0, exp_txn});
  endtask

  task automatic release_null();
    drive_null();
    ki = 1'b0;
    step();
    check("null", {15'd0, ko, out_dr, ovf_dr, neg_dr, zero_dr}, {15'd0, 1'b1, 16'd0});
  endtask

  task automatic directed(input int a, input int b, input logic [1:0] op, input logic cin,
                          input int er, input logic eo, input logic en, input logic ez);
    logic [W-1:0] av, bv, rv;
    av = a[W-1:0];
    bv = b[W-1:0];
    rv = er[W-1:0];
    capture(av, bv, op, cin);
    check("dir_val", {21'd0, dec(out_dr), ovf_dr, neg_dr, zero_dr},
          {21'd0, rv, e1(eo), e1(en), e1(ez)});
    release_null();
  endtask

  initial begin
    rst_n = 1'b0; ki = 1'b0; clr_err = 1'b0;
    drive_null();
    #1;
    check("reset_out", {15'd0, ko, out_dr, ovf_dr, neg_dr, zero_dr}, {15'd0, 1'b1, 16'd0});
    check("reset_err_txn", {14'd0, err_enc, err_timeout, txn_count}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1. 7+7 with exact rail pattern
    capture(5'd7, 5'd7, 2'd0, 1'b0);
    check("t1_rails", {22'd0, out_dr}, {22'd0, 10'b0110101001});
    release_null();

    // 2/3. arithmetic and logic corner cases
    directed(15, 15, 2'd0, 1'b0, -2, 1'b1, 1'b1, 1'b0);
    directed(10, 11, 2'd1, 1'b0, -1, 1'b0, 1'b1, 1'b0);
    directed(15, -15, 2'd1, 1'b1, -3, 1'b1, 1'b1, 1'b0);
    directed(-2, 2, 2'd0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    directed(8, 12, 2'd2, 1'b0, 4, 1'b0, 1'b0, 1'b0);
    directed(9, -15, 2'd3, 1'b0, 1, 1'b0, 1'b0, 1'b0);

    // 3. exhaustive sweep over all 13 logical input bits
    for (int v = 0; v < 8192; v++) begin
      capture(v[4:0], v[9:5], v[11:10], v[12]);
      release_null();
    end

    // 4. no capture without consumer request; HOLD ignores new DATA and NULL with ki=1
    drive_data(5'd3, 5'd4, 2'd0, 1'b0);
    ki = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("noack", {14'd0, ko, out_dr[0], txn_count}, {14'd0, 1'b1, 1'b0, exp_txn});
    end
    capture(5'd3, 5'd4, 2'd0, 1'b0);
    drive_data(5'd9, 5'd1, 2'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold", {15'd0, ko, out_dr, ovf_dr, neg_dr, zero_dr},
            {15'd0, 1'b0, enc(5'd7), 2'b01, 2'b01, 2'b01});
    end
    drive_null();
    ki = 1'b1;
    step();
    check("hold_ki1", {21'd0, ko, out_dr}, {21'd0, 1'b0, enc(5'd7)});
    release_null();
    check("hold_txn", {16'd0, txn_count}, {16'd0, exp_txn});

    // 5. illegal encoding, clear priority, timeout boundary
    drive_data(5'd1, 5'd2, 2'd0, 1'b0);
    a_dr[1:0] = 2'b11;
    ki = 1'b1;
    step();
    check("enc_set", {14'd0, err_enc, ko, txn_count}, {14'd0, 1'b1, 1'b1, exp_txn});
    check("enc_nocap", {22'd0, out_dr}, 32'd0);
    clr_err = 1'b1;
    step();
    check("clr_prio", {31'd0, err_enc}, 32'd0);
    clr_err = 1'b0;
    step();
    check("enc_reset", {31'd0, err_enc}, 32'd1);
    drive_null();
    step();
    a_dr = enc(5'd6);
    for (int i = 0; i < TO - 1; i++) step();
    check("to_below", {31'd0, err_timeout}, 32'd0);
    step();
    check("to_at", {31'd0, err_timeout}, 32'd1);
    check("to_nocap", {16'd0, ko, 15'd0}, {16'd0, 1'b1, 15'd0});
    drive_null();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("clr_both", {30'd0, err_enc, err_timeout}, 32'd0);
    step();
    check("clr_stays", {30'd0, err_enc, err_timeout}, 32'd0);

    // random traffic with random ki=0 stalls and NULL gaps
    for (int n = 0; n < 300; n++) begin
      logic [W-1:0] ra, rb;
      logic [1:0] rop;
      logic rc;
      ra = W'($urandom);
      rb = W'($urandom);
      rop = 2'($urandom);
      rc = 1'($urandom);
      drive_data(ra, rb, rop, rc);
      ki = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        step();
        check("rnd_stall", {31'd0, ko}, 32'd1);
      end
      capture(ra, rb, rop, rc);
      release_null();
      repeat ($urandom_range(0, 2)) step();
    end
    check("rnd_errs", {30'd0, err_enc, err_timeout}, 32'd0);

    // 6. asynchronous reset in HOLD, then clean resumption
    capture(5'd5, 5'd6, 2'd0, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_hold", {15'd0, ko, out_dr, ovf_dr, neg_dr, zero_dr}, {15'd0, 1'b1, 16'd0});
    check("rst_txn", {16'd0, txn_count}, 32'd0);
    exp_txn = '0;
    drive_null();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    capture(5'd12, 5'd3, 2'd1, 1'b0);
    release_null();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
